// File: rtl/serial_tx_frame_ctrl.sv
// Frame sequencer for the byte-wide serial TX path: fetches N_WORD words, sends them MSB-first,
// then appends the latched CRC. Define SERIAL_TX_HEADER_EN to prefix HDR_BYTE and N_WORD[7:0].
module serial_tx_frame_ctrl #(
  parameter int unsigned BYTES_PER_WORD = 2,
  parameter int unsigned N_WORD         = 8,
  parameter int unsigned DELAY_CYCLES   = 8,
  parameter logic [7:0]  HDR_BYTE       = 8'hA5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [8*BYTES_PER_WORD-1:0] data_in,
  input  logic [15:0]                 crc_16,
  input  logic                        tx_done,
  output logic [7:0]                  byte_out,
  output logic                        start_tx,
  output logic [7:0]                  data_select,
  output logic                        data_lock,
  output logic                        reset_crc,
  output logic                        ready
);

`ifdef SERIAL_TX_HEADER_EN
  localparam bit         HeaderEn  = 1'b1;
  localparam logic [7:0] WordCount = 8'(N_WORD);
`else
  localparam bit         HeaderEn  = 1'b0;
`endif
  localparam logic [7:0] LastWord  = 8'(N_WORD - 1);
  localparam logic [7:0] DelayLast = 8'(DELAY_CYCLES - 1);
  localparam logic [1:0] LastByte  = 2'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDelay,
`ifdef SERIAL_TX_HEADER_EN
    StHdr,
    StCnt,
`endif
    StData,
    StCrcHi,
    StCrcLo
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        start_tx_q, start_tx_d;
  logic [7:0]  data_select_q, data_select_d;
  logic        data_lock_q, data_lock_d;
  logic        reset_crc_q, reset_crc_d;
  logic        ready_q, ready_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  dly_cnt_q, dly_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        fetch_q, fetch_d;
  logic        tx_done_q;
  logic        tx_ev;

  // Byte idx of a word, counted from the most significant byte.
  function automatic logic [7:0] pick_byte(input logic [8*BYTES_PER_WORD-1:0] w,
                                           input logic [1:0] idx);
    logic [8*BYTES_PER_WORD-1:0] sh;
    sh = w >> (8 * (BYTES_PER_WORD - 1 - 32'(idx)));
    return sh[7:0];
  endfunction

  assign tx_ev = tx_done & ~tx_done_q;

  always_comb begin
    state_d       = state_q;
    byte_out_d    = byte_out_q;
    start_tx_d    = 1'b0;
    data_select_d = data_select_q;
    data_lock_d   = 1'b0;
    reset_crc_d   = reset_crc_q;
    crc_d         = crc_q;
    dly_cnt_d     = dly_cnt_q;
    byte_idx_d    = byte_idx_q;
    fetch_d       = fetch_q;

    unique case (state_q)
      StIdle: begin
        if (start && ready_q) begin
          state_d       = StDelay;
          reset_crc_d   = 1'b0;
          data_lock_d   = 1'b1;
          data_select_d = '0;
          dly_cnt_d     = '0;
        end
      end
      StDelay: begin
        if (dly_cnt_q == DelayLast) begin
          start_tx_d = 1'b1;
          byte_idx_d = '0;
          fetch_d    = 1'b0;
          byte_out_d = HeaderEn ? HDR_BYTE : pick_byte(data_in, 2'd0);
`ifdef SERIAL_TX_HEADER_EN
          state_d    = StHdr;
`else
          state_d    = StData;
`endif
        end else begin
          dly_cnt_d = dly_cnt_q + 8'd1;
        end
      end
`ifdef SERIAL_TX_HEADER_EN
      StHdr: begin
        if (tx_ev) begin
          byte_out_d = WordCount;
          start_tx_d = 1'b1;
          state_d    = StCnt;
        end
      end
      StCnt: begin
        if (tx_ev) begin
          byte_out_d = pick_byte(data_in, 2'd0);
          start_tx_d = 1'b1;
          state_d    = StData;
        end
      end
`endif
      StData: begin
        if (fetch_q) begin
          // New word has been locked for a cycle; its first byte is now stable.
          fetch_d    = 1'b0;
          byte_idx_d = '0;
          byte_out_d = pick_byte(data_in, 2'd0);
          start_tx_d = 1'b1;
        end else if (tx_ev) begin
          if (byte_idx_q != LastByte) begin
            byte_idx_d = byte_idx_q + 2'd1;
            byte_out_d = pick_byte(data_in, byte_idx_q + 2'd1);
            start_tx_d = 1'b1;
          end else if (data_select_q == LastWord) begin
            crc_d         = crc_16;
            byte_out_d    = crc_16[15:8];
            start_tx_d    = 1'b1;
            data_select_d = '0;
            reset_crc_d   = 1'b1;
            state_d       = StCrcHi;
          end else begin
            data_select_d = data_select_q + 8'd1;
            data_lock_d   = 1'b1;
            fetch_d       = 1'b1;
          end
        end
      end
      StCrcHi: begin
        if (tx_ev) begin
          byte_out_d = crc_q[7:0];
          start_tx_d = 1'b1;
          state_d    = StCrcLo;
        end
      end
      StCrcLo: begin
        if (tx_ev) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      byte_out_q    <= '0;
      start_tx_q    <= 1'b0;
      data_select_q <= '0;
      data_lock_q   <= 1'b0;
      reset_crc_q   <= 1'b1;
      ready_q       <= 1'b0;
      crc_q         <= '0;
      dly_cnt_q     <= '0;
      byte_idx_q    <= '0;
      fetch_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_out_q    <= byte_out_d;
      start_tx_q    <= start_tx_d;
      data_select_q <= data_select_d;
      data_lock_q   <= data_lock_d;
      reset_crc_q   <= reset_crc_d;
      ready_q       <= ready_d;
      crc_q         <= crc_d;
      dly_cnt_q     <= dly_cnt_d;
      byte_idx_q    <= byte_idx_d;
      fetch_q       <= fetch_d;
    end
  end

  // Edge-detect history runs through reset so a level held across release is not an event.
  always_ff @(posedge clk) begin
    tx_done_q <= tx_done;
  end

  assign byte_out    = byte_out_q;
  assign start_tx    = start_tx_q;
  assign data_select = data_select_q;
  assign data_lock   = data_lock_q;
  assign reset_crc   = reset_crc_q;
  assign ready       = ready_q;

endmodule

// File: tb/tb_serial_tx_frame_ctrl.sv
// Self-checking bench for serial_tx_frame_ctrl: a UART responder drives tx_done, and every frame
// is compared with a byte list built from the words and CRC value.
module tb_serial_tx_frame_ctrl;
  localparam int unsigned BPW = 2;
  localparam int unsigned NW  = 2;
  localparam int unsigned DLY = 6;
  localparam logic [7:0]  HDR = 8'hA5;
`ifdef SERIAL_TX_HEADER_EN
  localparam int unsigned HdrLen = 2;
`else
  localparam int unsigned HdrLen = 0;
`endif
  localparam int unsigned FrameLen = NW * BPW + 2 + HdrLen;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [8*BPW-1:0] data_in;
  logic [15:0]    crc_16;
  logic           tx_done;
  logic [7:0]     byte_out;
  logic           start_tx;
  logic [7:0]     data_select;
  logic           data_lock;
  logic           reset_crc;
  logic           ready;

  logic [8*BPW-1:0] words [NW];
  logic [7:0]       exp_q [$];
  logic [7:0]       got_q [$];
  int               n_cmp = 0;
  int               n_bad = 0;
  bit               aborted;

  always #5 clk = ~clk;

  // The word source presents the selected word combinationally.
  assign data_in = (data_select < 8'(NW)) ? words[data_select] : '0;

  serial_tx_frame_ctrl #(
    .BYTES_PER_WORD(BPW),
    .N_WORD        (NW),
    .DELAY_CYCLES  (DLY),
    .HDR_BYTE      (HDR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .crc_16     (crc_16),
    .tx_done    (tx_done),
    .byte_out   (byte_out),
    .start_tx   (start_tx),
    .data_select(data_select),
    .data_lock  (data_lock),
    .reset_crc  (reset_crc),
    .ready      (ready)
  );

  task automatic build_expected(input logic [15:0] crc);
    exp_q.delete();
`ifdef SERIAL_TX_HEADER_EN
    exp_q.push_back(HDR);
    exp_q.push_back(8'(NW));
`endif
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < BPW; b++)
        exp_q.push_back(8'(words[w] >> (8 * (BPW - 1 - b))));
    exp_q.push_back(crc[15:8]);
    exp_q.push_back(crc[7:0]);
  endtask

  task automatic randomize_words();
    for (int w = 0; w < NW; w++) words[w] = (8*BPW)'($urandom);
    crc_16 = 16'($urandom);
  endtask

  // Runs one frame with a UART responder; checks protocol invariants and the byte list.
  task automatic do_frame(input string nm, input int hold_lo, input int hold_hi, input bit glitch,
                          input bit start_mid, input bit crc_zero, input int abort_after);
    int pend, wait_cnt, hold, st, cyc, extra, rst_crc_bad, ready_bad, sel_bad, locks;
    bit crc_phase, final_rise, done, ready_ok;
    pend = 0; wait_cnt = 0; hold = 0; st = 0; cyc = 0; extra = 0;
    rst_crc_bad = 0; ready_bad = 0; sel_bad = 0; locks = 0;
    crc_phase = 0; final_rise = 0; done = 0; ready_ok = 0; aborted = 0;
    build_expected(crc_16);
    got_q.delete();
    while (ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_wait: ready=%b want 1", nm, ready);
      return;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      if (data_lock === 1'b1) locks++;
      if (data_select >= 8'(NW)) sel_bad++;
      if (start_tx === 1'b1) begin
        got_q.push_back(byte_out);
        pend++;
        if (got_q.size() == FrameLen - 1) crc_phase = 1;
      end
      if (reset_crc !== crc_phase) rst_crc_bad++;
      if (final_rise) begin
        ready_ok = (ready === 1'b1);
        done = 1;
      end else if (ready !== 1'b0) begin
        ready_bad++;
      end
      if (abort_after > 0 && got_q.size() == abort_after) begin
        aborted = 1;
        return;
      end
      if (!done) begin
        if (crc_zero && crc_phase) crc_16 = '0;
        start = start_mid && (got_q.size() == HdrLen + 2);
        if (glitch && cyc == 1) tx_done = 1'b1;
        if (glitch && cyc == 2) tx_done = 1'b0;
        if (st == 0 && pend > 0) begin
          pend--;
          st = 1;
          wait_cnt = $urandom_range(3, 1);
        end
        if (st == 1) begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            tx_done = 1'b1;
            hold = $urandom_range(hold_hi, hold_lo);
            st = 2;
            if (got_q.size() == FrameLen && pend == 0) final_rise = 1;
          end
        end else if (st == 2) begin
          hold--;
          if (hold == 0) begin
            tx_done = 1'b0;
            st = 0;
          end
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) tx_done = 1'b0;
      @(negedge clk);
      if (start_tx === 1'b1) extra++;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s timeout: got %0d bytes want %0d", nm, got_q.size(), FrameLen);
    end
    n_cmp++;
    if (got_q.size() != FrameLen) begin
      n_bad++;
      $display("FAIL %s length: got %0d want %0d", nm, got_q.size(), FrameLen);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s byte%0d: got %h want %h", nm, i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (locks != NW) begin
      n_bad++;
      $display("FAIL %s data_lock_count: got %0d want %0d", nm, locks, NW);
    end
    n_cmp++;
    if (rst_crc_bad != 0) begin
      n_bad++;
      $display("FAIL %s reset_crc: %0d bad cycles want 0", nm, rst_crc_bad);
    end
    n_cmp++;
    if (ready_bad != 0 || !ready_ok) begin
      n_bad++;
      $display("FAIL %s ready: %0d early cycles, after_last=%0d want 0/1", nm, ready_bad, ready_ok);
    end
    n_cmp++;
    if (sel_bad != 0 || data_select !== 8'd0) begin
      n_bad++;
      $display("FAIL %s data_select: %0d out of range, end=%0d want 0/0", nm, sel_bad,
               data_select);
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL %s stray_start_tx: got %0d want 0", nm, extra);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; tx_done = 1'b0; crc_16 = '0;
    for (int w = 0; w < NW; w++) words[w] = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (byte_out !== 8'h00 || start_tx !== 1'b0 || data_select !== 8'h00 ||
        data_lock !== 1'b0 || reset_crc !== 1'b1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: got %h %b %h %b %b %b want 00 0 00 0 1 0", byte_out,
               start_tx, data_select, data_lock, reset_crc, ready);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b want 1", ready);
    end
  endtask

  task automatic test_directed();
    logic [7:0] lit [6];
    lit = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'hEF};
    words[0] = 16'h1234; words[1] = 16'hABCD; crc_16 = 16'hBEEF;
    do_frame("directed", 1, 1, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (got_q.size() != FrameLen || got_q[HdrLen + i] !== lit[i]) begin
        n_bad++;
        $display("FAIL directed_lit%0d: got %h want %h", i,
                 (got_q.size() > HdrLen + i) ? got_q[HdrLen + i] : 8'hxx, lit[i]);
      end
    end
  endtask

  task automatic test_crc_clear();
    words[0] = 16'h1234; words[1] = 16'hABCD; crc_16 = 16'hBEEF;
    do_frame("crc_clear", 1, 3, 1'b0, 1'b0, 1'b1, 0);
    n_cmp++;
    if (got_q.size() != FrameLen || got_q[FrameLen - 1] !== 8'hEF || reset_crc !== 1'b1) begin
      n_bad++;
      $display("FAIL crc_clear_low: got %h reset_crc=%b want ef 1",
               (got_q.size() == FrameLen) ? got_q[FrameLen - 1] : 8'hxx, reset_crc);
    end
  endtask

  task automatic test_held_done();
    randomize_words();
    do_frame("held_done", 5, 5, 1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      randomize_words();
      do_frame($sformatf("random%0d", f), 1, 4, f[0], 1'b0, 1'b0, 0);
    end
  endtask

  task automatic test_start_ignored();
    randomize_words();
    do_frame("start_ignored", 1, 2, 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    int pulses;
    randomize_words();
    do_frame("reset_mid_pre", 1, 2, 1'b0, 1'b0, 1'b0, 3);
    n_cmp++;
    if (!aborted) begin
      n_bad++;
      $display("FAIL reset_mid_reach3: got %0d bytes want 3", got_q.size());
    end
    reset = 1'b1; tx_done = 1'b0; start = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (start_tx === 1'b1) pulses++;
    end
    n_cmp++;
    if (data_select !== 8'h00 || reset_crc !== 1'b1 || ready !== 1'b0 || byte_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid_values: got sel=%h crc=%b rdy=%b byte=%h want 00 1 0 00",
               data_select, reset_crc, ready, byte_out);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_ready: got %b want 1", ready);
    end
    repeat (4) begin
      @(negedge clk);
      if (start_tx === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL reset_mid_start_tx: got %0d pulses want 0", pulses);
    end
    randomize_words();
    do_frame("reset_mid_post", 1, 3, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      randomize_words();
      do_frame($sformatf("b2b%0d", f), 1, 1, 1'b0, 1'b0, 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_crc_clear();
    test_held_done();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_tx_frame_ctrl.md
Name: serial_tx_frame_ctrl

Overview:
Parametrised frame sequencer for the byte-wide serial transmitter.
- Fetches N_WORD words of BYTES_PER_WORD bytes each from an external word mux (data_select/data_in).
- Serialises them MSB-first into a byte UART via start_tx/tx_done, then appends a 16-bit CRC taken from the external CRC engine.
- Sits between the control-loop register bank and the UART TX core; this is the generalised successor of the fixed 16-bit-word TX controller.

Parameters:
BYTES_PER_WORD, 2, bytes per data word (1..4); data_in width = 8*BYTES_PER_WORD.
N_WORD, 8, words per frame (1..255).
DELAY_CYCLES, 8, idle cycles between start acceptance and first byte (1..255).
HDR_BYTE, 8'hA5, sync byte used only when the header feature is enabled.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  frame request, sampled only while ready=1
data_in  in  8*BYTES_PER_WORD  word selected by data_select
crc_16  in  16  running CRC of transmitted bytes
tx_done  in  1  UART byte-complete level; rising edge = byte finished
byte_out  out  8  byte presented to UART
start_tx  out  1  one-cycle UART start pulse
data_select  out  8  index of the word being fetched
data_lock  out  1  one-cycle strobe: source freezes data_in at the current data_select
reset_crc  out  1  CRC engine clear, level
ready  out  1  idle and able to accept start

Behaviour:
- Reset values: byte_out=0, start_tx=0, data_select=0, data_lock=0, reset_crc=1, ready=0. State goes to IDLE and all counters clear. ready rises the cycle after reset is released.
- Edge detect: tx_ev = tx_done & ~tx_done_d. tx_done_d is registered every cycle, including during reset. A tx_done level held high advances the machine exactly once.
- States: IDLE, DELAY, [HDR, CNT], DATA, CRC_HI, CRC_LO.
- IDLE
  - ready=1.
  - When start=1: next cycle ready=0, reset_crc=0, data_lock pulses, data_select=0, then go to DELAY.
  - start is ignored in every other state.
- DELAY
  - Counts DELAY_CYCLES cycles.
  - On exit, loads the first frame byte into byte_out and pulses start_tx for 1 cycle.
  - The first byte is HDR_BYTE if the header feature is enabled, otherwise data_in[MSB byte].
- DATA
  - A byte counter b (0..BYTES_PER_WORD-1) selects data_in[8*(BYTES_PER_WORD-1-b) +: 8].
  - On each tx_ev, the next byte is registered into byte_out and start_tx pulses in the same registered cycle.
  - After the last byte of a word, data_select increments and data_lock pulses on the same edge.
  - The next word's first byte is taken one cycle later, after the lock settles. That byte's start_tx is therefore one cycle later than intra-word bytes.
- Last data byte: on its tx_ev, the full crc_16 is latched into crc_q, byte_out=crc_q[15:8], start_tx pulses, data_select returns to 0, reset_crc=1, and the state goes to CRC_HI.
  - The CRC low byte therefore comes from the latched value and is immune to the clear.
- CRC_HI: on tx_ev, byte_out=crc_q[7:0], start_tx pulses, go to CRC_LO.
- CRC_LO: on tx_ev, go to IDLE; ready=1 on the following cycle.
- Frame length: N_WORD*BYTES_PER_WORD+2 bytes (+2 with header). Exactly that many start_tx pulses per frame.
- tx_ev in IDLE or DELAY is ignored.
- Reset mid-frame: immediate return to IDLE with reset values. No further start_tx pulse is issued.
- data_select wraps only via the frame end; it never exceeds N_WORD-1.

Optional Feature:
Macro SERIAL_TX_HEADER_EN.
- Defined: states HDR and CNT are compiled in. The frame starts with HDR_BYTE, then N_WORD[7:0], each advanced on tx_ev. Both bytes are included in the CRC (reset_crc is already low).
- Undefined: HDR/CNT are absent; DELAY goes directly to the first data byte.

Test Plan:
1. Defaults, BYTES_PER_WORD=2, N_WORD=2, words 0x1234/0xABCD, crc_16=0xBEEF at last-byte edge -> byte_out sequence 12,34,AB,CD,BE,EF; 6 start_tx pulses; ready=1 one cycle after 6th tx_ev.
2. crc_16 changed to 0x0000 right after the CRC_HI entry -> low CRC byte still EF; reset_crc=1 from CRC_HI until next start.
3. SERIAL_TX_HEADER_EN, N_WORD=2 -> A5,02,12,34,AB,CD,crc hi,crc lo; 8 pulses.
4. tx_done held high 5 cycles per byte, plus tx_done pulses during DELAY -> single advance per byte; no extra start_tx.
5. BYTES_PER_WORD=3, N_WORD=1, data 0xC0FFEE -> C0,FF,EE,crc hi,crc lo; data_select 0 throughout.
6. start during DATA ignored; reset asserted after 3rd byte -> start_tx stays 0, ready returns to 1 after release, next frame restarts from word 0.
